mem_line_ctrl: RTL

MEM_LINE_CTRL -- requirements
Module: mem_line_ctrl

---
 rtl/mem_line_ctrl_if.sv | 31 +++
 rtl/mem_line_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_line_ctrl_if.sv
// Cache-to-backing-memory line transfer bus.
// master = cache side, slave = memory side.
interface mem_line_ctrl_if;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wline;
  logic [127:0] mem_rline;
  logic         mem_ready;
  logic         mem_busy;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wline,
    input  mem_rline,
    input  mem_ready,
    input  mem_busy
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wline,
    output mem_rline,
    output mem_ready,
    output mem_busy
  );
endinterface

// File: rtl/mem_line_ctrl.sv
// Fixed-latency 128-bit line backing store for the data cache.
// One request in flight; fill or write-back commits after LATENCY cycles.
module mem_line_ctrl #(
  parameter int LATENCY   = 4,
  parameter int MEM_LINES = 256
) (
  input  logic            CLK,
  input  logic            RST,
  mem_line_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_LINES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [3:0]         cnt;
  logic [3:0]         cnt_nx;
  logic               we_q;
  logic [IDX_W-1:0]   idx_q;
  logic [127:0]       wline_q;
  logic [127:0]       rline_q;
  logic               ready_q;
  logic               busy_q;
  logic               accept;
  logic               commit;
  logic [IDX_W-1:0]   idx_in;

  // Storage starts at zero and is deliberately untouched by RST.
  logic [127:0] mem [MEM_LINES] = '{default: '0};

  // Offset and upper address bits drop out, so lines alias.
  assign idx_in = IDX_W'(bus.mem_addr >> 4);
  assign accept = (state == IDLE) && bus.mem_req;
  assign commit = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.mem_req) begin
          state_nx = WAIT;
          cnt_nx   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      rline_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ready_q <= (state_nx == RESP);
      busy_q  <= (state_nx != IDLE);
      if (commit && !we_q) begin
        rline_q <= mem[idx_q];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && accept) begin
      we_q    <= bus.mem_we;
      idx_q   <= idx_in;
      wline_q <= bus.mem_wline;
    end
  end

  // A reset landing on the commit edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && commit && we_q) begin
      mem[idx_q] <= wline_q;
    end
  end

  assign bus.mem_rline = rline_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_busy  = busy_q;

endmodule
